// File: rtl/bit_stream_serializer_pkg.sv
// Shared types and defaults for the bit-stream serializer: FSM state encoding,
// default widths and the bit-counter width helper.
package bit_stream_serializer_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bit_stream_serializer_period_counter.sv
// Bit-period down-counter: counts the latched divider down to zero, reloads, and
// raises a registered terminal-count pulse on the final clock of each period.
module bit_period_counter #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_val,
  input  logic             run,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // sees pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      period <= '0;
      tc     <= 1'b0;
    end else if (load) begin
      cnt    <= load_val;
      period <= load_val;
      tc     <= (load_val == '0);
    end else if (run) begin
      // tc is registered one cycle ahead: it rises when the counter reaches zero.
      if (cnt == '0) begin
        cnt <= period;
        tc  <= (period == '0);
      end else begin
        cnt <= cnt - 1'b1;
        tc  <= (cnt == DIV_W'(1));
      end
    end else begin
      cnt <= '0;
      tc  <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial feeder for the sequence detector: one-entry hold register,
// shifter and IDLE/SHIFT FSM; the bit period comes from bit_period_counter.
module bit_stream_serializer
  import bit_stream_serializer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              msb_first,
  input  logic [DIV_W-1:0]  div,
  output logic              ser_bit,
  output logic              ser_strobe,
  output logic              busy
);

  localparam int CNT_W = cnt_w(DATA_W);

  state_e            state;
  logic              out_en;
  logic              hold_full;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              msb_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic              last_bit;
  logic              load;
  logic              run;
  logic              load_bit;

  assign last_bit = (state == ST_SHIFT) && ser_strobe && (bit_cnt == '0);
  assign load     = hold_full && ((state == ST_IDLE) || last_bit);
  assign run      = (state == ST_SHIFT) && !last_bit;
  assign in_ready = out_en & ~hold_full;
  assign busy     = (state == ST_SHIFT) | hold_full;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    shift_next = shift_reg;
    load_bit   = 1'b0;
    if (msb_q) shift_next = shift_reg << 1;
    else       shift_next = shift_reg >> 1;
    load_bit = msb_first ? hold_data[DATA_W-1] : hold_data[0];
  end

  // in_ready stays low through reset and rises one clock after release.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_en <= 1'b0;
    else     out_en <= 1'b1;
  end

  // NOTE: the hold data register is reset along with its flag; it is a single
  // word, so a defined value costs nothing and keeps simulation free of X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (in_valid && in_ready) begin
      hold_full <= 1'b1;
      hold_data <= in_data;
    end else if (load) begin
      hold_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      msb_q     <= 1'b0;
      bit_cnt   <= '0;
      ser_bit   <= 1'b0;
    end else if (load) begin
      state     <= ST_SHIFT;
      shift_reg <= hold_data;
      msb_q     <= msb_first;
      bit_cnt   <= CNT_W'(DATA_W - 1);
      ser_bit   <= load_bit;
    end else if (state == ST_SHIFT && ser_strobe) begin
      if (bit_cnt == '0) begin
        state   <= ST_IDLE;
        ser_bit <= 1'b0;
      end else begin
        shift_reg <= shift_next;
        bit_cnt   <= bit_cnt - 1'b1;
        ser_bit   <= msb_q ? shift_next[DATA_W-1] : shift_next[0];
      end
    end
  end

  bit_period_counter #(
    .DIV_W(DIV_W)
  ) u_period (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_val (div),
    .run      (run),
    .tc       (ser_strobe)
  );

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Scoreboard bench for bit_stream_serializer: directed words push expected
// (bit, strobe cycle) pairs; a monitor pops and compares on every ser_strobe.
module tb_bit_stream_serializer;

  typedef struct {
    logic b;
    int   cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       msb_first = 1'b0;
  logic [7:0] div = '0;
  logic       ser_bit;
  logic       ser_strobe;
  logic       busy;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  int   strobe_count = 0;
  int   next_free = 0;

  bit_stream_serializer #(.DATA_W(8), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .msb_first  (msb_first),
    .div        (div),
    .ser_bit    (ser_bit),
    .ser_strobe (ser_strobe),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every strobe must match the oldest expected bit and its cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ser_strobe) begin
        strobe_count++;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 32'(ser_strobe), 32'(0));
        end else begin
          e = exp_q.pop_front();
          check("ser_bit", 32'(ser_bit), 32'(e.b));
          check("strobe_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
    end
  endtask

  // seq lists the bits in emission order, seq[7] first. start returns the
  // first cycle in which the word's first bit is on ser_bit.
  task automatic send(input logic [7:0] data, input logic msb, input logic [7:0] d,
                      input logic [7:0] seq, input bit wait_load, output int start);
    int n = 0;
    int acc;
    in_data   = data;
    msb_first = msb;
    div       = d;
    in_valid  = 1'b1;
    while (!in_ready && n < 400) begin
      step(1);
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
      start = cyc;
      return;
    end
    acc   = cyc + 1;
    start = (acc + 1 > next_free) ? acc + 1 : next_free;
    for (int k = 0; k < 8; k++)
      exp_q.push_back('{b: seq[7-k], cyc: start + int'(d) + k * (int'(d) + 1)});
    next_free = start + 8 * (int'(d) + 1);
    step(1);
    in_valid = 1'b0;
    if (wait_load) while (cyc < start) step(1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      step(1);
      n++;
    end
    check("drain_queue_empty", 32'(exp_q.size()), 32'(0));
    step(3);
  endtask

  initial begin
    int s1;
    int s2;
    int base;
    int saved;
    bit bad;

    // Reset state and in_ready one clock after release.
    step(3);
    check("rst_ser_bit", 32'(ser_bit), 32'(0));
    check("rst_ser_strobe", 32'(ser_strobe), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    rst = 1'b0;
    #1;
    check("release_in_ready_same_cycle", 32'(in_ready), 32'(0));
    step(1);
    check("release_in_ready_next", 32'(in_ready), 32'(1));
    check("idle_busy", 32'(busy), 32'(0));

    // div=0, MSB first: one bit per clock, strobe continuously high.
    send(8'b1101_0000, 1'b1, 8'd0, 8'b1101_0000, 1'b1, s1);
    check("div0_strobe_high", 32'(ser_strobe), 32'(1));
    drain();
    check("idle_ser_bit", 32'(ser_bit), 32'(0));

    // div=3, LSB first: 1,0,1,0,0,1,0,1 at period 4.
    send(8'hA5, 1'b0, 8'd3, 8'b1010_0101, 1'b1, s1);
    drain();

    // Back-to-back words at div=1; the held word blocks in_ready.
    send(8'hFF, 1'b1, 8'd1, 8'hFF, 1'b1, s1);
    send(8'h00, 1'b1, 8'd1, 8'h00, 1'b0, s2);
    check("b2b_in_ready_held", 32'(in_ready), 32'(0));
    in_data  = 8'h5A;
    in_valid = 1'b1;
    step(3);
    in_valid = 1'b0;
    bad = 1'b0;
    while (cyc < next_free) begin
      if (!busy) bad = 1'b1;
      step(1);
    end
    check("b2b_busy_continuous", 32'(bad), 32'(0));
    drain();
    check("b2b_busy_after", 32'(busy), 32'(0));

    // div changed mid-word: 8'h96 keeps period 3; 8'h0F LSB-first runs at period 1.
    send(8'h96, 1'b1, 8'd2, 8'b1001_0110, 1'b1, s1);
    step(4);
    div       = 8'd0;
    msb_first = 1'b0;
    send(8'h0F, 1'b0, 8'd0, 8'hF0, 1'b1, s2);
    drain();

    // div all-ones: period 256 clocks, no counter overflow.
    send(8'h81, 1'b1, 8'hFF, 8'h81, 1'b1, s1);
    drain();

    // Reset during bit 4 of 8'hFF with 8'h3C held: nothing further appears.
    base = strobe_count;
    send(8'hFF, 1'b1, 8'd1, 8'hFF, 1'b1, s1);
    send(8'h3C, 1'b1, 8'd1, 8'h3C, 1'b0, s2);
    begin
      int n = 0;
      while (strobe_count < base + 4 && n < 200) begin
        step(1);
        n++;
      end
    end
    check("pre_reset_strobes", 32'(strobe_count), 32'(base + 4));
    step(1);
    check("pre_reset_busy", 32'(busy), 32'(1));
    rst = 1'b1;
    #1;
    exp_q.delete();
    next_free = 0;
    check("midrst_ser_bit", 32'(ser_bit), 32'(0));
    check("midrst_ser_strobe", 32'(ser_strobe), 32'(0));
    check("midrst_busy", 32'(busy), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(0));
    step(2);
    rst = 1'b0;
    saved = strobe_count;
    step(1);
    check("postrst_in_ready", 32'(in_ready), 32'(1));
    step(40);
    check("postrst_no_strobes", 32'(strobe_count), 32'(saved));
    check("postrst_busy", 32'(busy), 32'(0));
    check("postrst_ser_bit", 32'(ser_bit), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
